// File: rtl/wide_add_pkg.sv
// Shared constants, state encoding and sizing helper for the wide-operand adder sequencer.
package wide_add_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/adder_32_1.sv
// 32-bit carry-lookahead adder slice: 4-bit lookahead groups, group carries chained.
module adder_32_1 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      // Group generate/propagate gives the carry into the next group directly.
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign s     = p ^ c[31:0];
  assign c_out = c[32];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one 32-bit word per clock through a shared CLA slice, LSW first.
// Optional signed-overflow output enabled by defining WIDE_ADD_OVF_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_W*WORDS-1:0]   a,
  input  logic [WORD_W*WORDS-1:0]   b,
  input  logic                      c_in,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_W*WORDS-1:0]   s,
  output logic                      c_out
`ifdef WIDE_ADD_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int unsigned W    = WORD_W * WORDS;
  localparam int unsigned IdxW = idx_width(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    s_q, s_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            accept;

  logic [WORD_W-1:0] slice_a, slice_b, slice_s;
  logic              slice_c;

  assign accept  = start && (state_q != StRun);
  assign slice_a = a_q[WORD_W*idx_q +: WORD_W];
  assign slice_b = b_q[WORD_W*idx_q +: WORD_W];

  adder_32_1 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

`ifdef WIDE_ADD_OVF_EN
  logic ovf_q, ovf_d;
  logic top_msb_cin;

  // Only meaningful on the top-word edge, which is the only time ovf_d is taken.
  assign top_msb_cin = a_q[W-1] ^ b_q[W-1] ^ slice_s[WORD_W-1];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    work_d  = work_q;
    s_d     = s_q;
    c_out_d = c_out_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        work_d[WORD_W*idx_q +: WORD_W] = slice_s;
        carry_d = slice_c;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
          s_d     = work_d;
          c_out_d = slice_c;
`ifdef WIDE_ADD_OVF_EN
          ovf_d   = top_msb_cin ^ slice_c;
`endif
        end
      end
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
    if (accept) begin
      idx_d   = '0;
      carry_d = c_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

`ifdef WIDE_ADD_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign s     = s_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized self-checking bench for wide_add_seq against a plain-arithmetic sum model.
// Define WIDE_ADD_OVF_EN in both RTL and bench builds to exercise the overflow output.
module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         busy, done, c_out;
  logic [W-1:0] s;
`ifdef WIDE_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out)
`ifdef WIDE_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word_mix();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       v[32*i +: 32] = 32'hFFFF_FFFF;
        1:       v[32*i +: 32] = 32'h0;
        default: v[32*i +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  function automatic logic [W:0] model_sum(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci);
    return {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
  endfunction

  // Called at the negedge following the accepting edge; counts edges until done.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci);
    logic [W:0] exp_sum;
    int edges, bcnt;
    exp_sum = model_sum(av, bv, ci);
    @(negedge clk);
    a = av; b = bv; c_in = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = rand_word_mix(); b = rand_word_mix(); c_in = 1'($urandom);
    wait_done(edges, bcnt);
    check_eq({tag, ".latency"}, edges, WORDS);
    check_eq({tag, ".busy_cycles"}, bcnt, WORDS);
    check_eq({tag, ".s"}, s, exp_sum[W-1:0]);
    check_eq({tag, ".c_out"}, c_out, exp_sum[W]);
`ifdef WIDE_ADD_OVF_EN
    check_eq({tag, ".ovf"}, ovf,
             (av[W-1] == bv[W-1]) && (exp_sum[W-1] != av[W-1]));
`endif
    @(negedge clk);
    check_eq({tag, ".done_drop"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] av1, bv1, av2, bv2, ones;
    logic [W:0]   sum1, sum2;
    int e, bc, dc0;

    ones  = '1;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.busy", busy, 1'b0);
    check_eq("reset.done", done, 1'b0);
    check_eq("reset.s", s, '0);
    check_eq("reset.c_out", c_out, 1'b0);
    rst = 1'b0;

    run_op("ones_plus_one", ones, W'(1), 1'b0);
    run_op("inter_word_carry", W'(64'hFFFF_FFFF), W'(1), 1'b0);

    // Extra start and operand change during RUN must be ignored.
    dc0 = done_cnt;
    @(negedge clk);
    a = W'(5); b = W'(7); c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = W'(100); b = W'(200); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check_eq("run_ignore.done_count", done_cnt - dc0, 1);
    check_eq("run_ignore.s", s, W'(12));
    check_eq("run_ignore.c_out", c_out, 1'b0);

    // Asynchronous reset after the second RUN edge aborts without publishing.
    @(negedge clk);
    a = rand_word_mix(); b = rand_word_mix(); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort.busy", busy, 1'b0);
    check_eq("abort.done", done, 1'b0);
    check_eq("abort.s", s, '0);
    check_eq("abort.c_out", c_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", W'(1), W'(2), 1'b0);

    // Back-to-back: start held high, second operands presented in the DONE cycle.
    av1 = rand_word_mix(); bv1 = rand_word_mix();
    av2 = rand_word_mix(); bv2 = rand_word_mix();
    sum1 = model_sum(av1, bv1, 1'b1);
    sum2 = model_sum(av2, bv2, 1'b0);
    @(negedge clk);
    a = av1; b = bv1; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = rand_word_mix(); b = rand_word_mix();
    wait_done(e, bc);
    check_eq("b2b.first_latency", e, WORDS);
    check_eq("b2b.first_s", s, sum1[W-1:0]);
    a = av2; b = bv2; c_in = 1'b0;
    e = 0;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (e == 1) start = 1'b0;
      if (e == 3) check_eq("b2b.s_hold", s, sum1[W-1:0]);
    end while (!done && e < 20);
    check_eq("b2b.spacing", e, WORDS + 1);
    check_eq("b2b.second_s", s, sum2[W-1:0]);
    check_eq("b2b.second_c_out", c_out, sum2[W]);
    @(negedge clk);
    check_eq("b2b.done_drop", done, 1'b0);

    run_op("ovf_pos", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    run_op("ovf_none", ones, W'(1), 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rand%0d", i), rand_word_mix(), rand_word_mix(), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide-operand adder sequencer. It adds two `32*WORDS`-bit operands using a single shared 32-bit carry-lookahead adder slice, one 32-bit word per clock, least-significant word first, with the carry registered between words. It sits between a requesting datapath, which issues a start pulse with operands, and the 32-bit adder. It handles operand capture, word selection, carry chaining, and result assembly and handshake.

## Interface
- `WORDS`, default 4: number of 32-bit words per operand, ≥ 2. Operand width is `32*WORDS`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when accepted (see Operation).
- `a` in `32*WORDS`: operand A, captured on the accepting edge.
- `b` in `32*WORDS`: operand B, captured on the accepting edge.
- `c_in` in 1: carry into word 0, captured on the accepting edge.
- `busy` out 1: high while words are being added (RUN).
- `done` out 1: one-cycle pulse; result valid.
- `s` out `32*WORDS`: sum; holds the last completed result.
- `c_out` out 1: carry out of the top word; holds the last completed result.
- `ovf` out 1: signed overflow. Present only with `WIDE_ADD_OVF_EN`.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `s`=0, `c_out`=0, `ovf`=0, word index 0, carry register 0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - IDLE, `start`=1: capture `a`, `b`, `c_in`, set index to 0, go to RUN. `start`=0 stays IDLE.
  - RUN: `start` is ignored. Operand inputs are don't-care and have no effect on the result.
  - DONE, `start`=1: same as IDLE acceptance (back-to-back). `start`=0 goes to IDLE.
- Each RUN edge:
  - The adder slice receives captured word[index] of A and B, plus the carry register (captured `c_in` for index 0).
  - The 32-bit sum is written into word[index] of an internal work register.
  - The slice carry-out is written into the carry register, and the index increments.
- When index = `WORDS-1`, the same edge also:
  - copies the full work register (including the final word) to `s`;
  - sets `c_out` to the slice carry-out;
  - enters DONE.
- `s` and `c_out` change only on DONE entry. Partial sums are never visible.
- Arithmetic is unsigned modulo `2^(32*WORDS)`, with `c_out` as bit `32*WORDS`.
- Asynchronous reset mid-RUN: abort immediately to reset values. A partial result is never published. The next accepted `start` behaves as from power-up.

## Timing
- Latency: if `start` is accepted on edge E0, words are added on edges E1..E_WORDS.
- `done`=1 and the new `s`/`c_out` are visible in the cycle after E_WORDS. `done` drops after E_WORDS+1.
- `busy` is high from after E0 through E_WORDS; it is low in DONE and IDLE.
- Throughput: back-to-back requests accepted in the DONE cycle complete every `WORDS+1` cycles.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- Macro `WIDE_ADD_OVF_EN`.
- Defined: port `ovf` exists. On DONE entry it is registered as (carry into bit 31 of the top word) XOR (carry out of the top word). Carry-in to the top MSB is derived as `a[MSB]^b[MSB]^sum[MSB]` from captured operands. Reset value is 0; it is held like `s`.
- Undefined: no `ovf` port or logic. All other behaviour is identical.

## Structure
- Package `wide_add_pkg`:
  - constant `WORD_W`=32;
  - state enum `{IDLE, RUN, DONE}`;
  - index width function `$clog2(WORDS)`.
- One sub-module: the existing 32-bit CLA wrapper `adder_32_1`, instantiated once as the shared slice. No other adder logic lives in this block.

## Test plan
- WORDS=4, `a`=all-ones (128 bits), `b`=1, `c_in`=0 → `s`=0 and `c_out`=1. `done` pulses exactly 4 edges after the accepting edge; `busy` is high for 4 cycles.
- `a`=`0x0000_0000_0000_0000_0000_0000_FFFF_FFFF`, `b`=1 → `s`=`0x...0001_0000_0000`, `c_out`=0. This checks the inter-word carry.
- Accept `a`=5, `b`=7. Change `a`/`b` and pulse `start` during RUN → result is 12, exactly one `done`, and the extra start is ignored.
- Hold `start`=1 continuously with new operands presented in the DONE cycle → a second `done` arrives exactly 5 cycles after the first, with the correct second sum. `s` holds the first sum until then.
- Assert `rst` after the 2nd RUN edge → `busy`/`done`/`s`/`c_out` go to 0 immediately. A following request `a`=1, `b`=2 gives `s`=3.
- With `WIDE_ADD_OVF_EN`: `a`=`0x7FFF...FFFF`, `b`=1 → `ovf`=1, `c_out`=0. `a`=all-ones, `b`=1 → `ovf`=0, `c_out`=1.
